// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one burst memory read port between the I-cache (m0)
// and the D-cache (m1); one burst in flight, beats routed to the granted requester only.
module mem_rd_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BEATS  = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  from_m0_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] from_m0_rd_req_addr,
  output logic                  to_m0_rd_req_ready,
  output logic                  to_m0_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] to_m0_rd_rsp_data,
  output logic                  to_m0_rd_rsp_last,
  input  logic                  from_m0_rd_rsp_ready,
  input  logic                  from_m1_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] from_m1_rd_req_addr,
  output logic                  to_m1_rd_req_ready,
  output logic                  to_m1_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] to_m1_rd_rsp_data,
  output logic                  to_m1_rd_rsp_last,
  input  logic                  from_m1_rd_rsp_ready,
  output logic                  to_mem_rd_req_valid,
  output logic [ADDR_WIDTH-1:0] to_mem_rd_req_addr,
  input  logic                  from_mem_rd_req_ready,
  input  logic                  from_mem_rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] from_mem_rd_rsp_data,
  input  logic                  from_mem_rd_rsp_last,
  output logic                  to_mem_rd_rsp_ready,
  output logic                  grant_id,
  output logic                  busy,
  output logic                  overrun_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax   = CNT_WIDTH'(MAX_BEATS);
  localparam logic [CNT_WIDTH-1:0] CntSat   = {CNT_WIDTH{1'b1}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  overrun_q, overrun_d;

  logic                  pick_m1;
  logic                  rsp_ready_sel;
  logic                  beat_xfer;

  // m1 wins when it is alone, or on a tie when m0 was served last.
  assign pick_m1 = from_m1_rd_req_valid & (~from_m0_rd_req_valid | ~last_grant_q);
  assign rsp_ready_sel = grant_q ? from_m1_rd_rsp_ready : from_m0_rd_rsp_ready;
  assign beat_xfer = (state_q == RSP) & from_mem_rd_rsp_valid & rsp_ready_sel;

  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    grant_d             = grant_q;
    last_grant_d        = last_grant_q;
    beat_cnt_d          = beat_cnt_q;
    overrun_d           = overrun_q;
    to_m0_rd_req_ready  = 1'b0;
    to_m1_rd_req_ready  = 1'b0;
    to_m0_rd_rsp_valid  = 1'b0;
    to_m1_rd_rsp_valid  = 1'b0;
    to_m0_rd_rsp_data   = '0;
    to_m1_rd_rsp_data   = '0;
    to_m0_rd_rsp_last   = 1'b0;
    to_m1_rd_rsp_last   = 1'b0;
    to_mem_rd_req_valid = 1'b0;
    to_mem_rd_rsp_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (from_m0_rd_req_valid || from_m1_rd_req_valid) begin
          grant_d            = pick_m1;
          addr_d             = pick_m1 ? from_m1_rd_req_addr : from_m0_rd_req_addr;
          beat_cnt_d         = '0;
          state_d            = REQ;
          to_m0_rd_req_ready = ~pick_m1;
          to_m1_rd_req_ready = pick_m1;
        end
      end
      REQ: begin
        to_mem_rd_req_valid = 1'b1;
        if (from_mem_rd_req_ready) begin
          state_d = RSP;
        end
      end
      RSP: begin
        to_mem_rd_rsp_ready = rsp_ready_sel;
        if (grant_q) begin
          to_m1_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_m1_rd_rsp_data  = from_mem_rd_rsp_data;
          to_m1_rd_rsp_last  = from_mem_rd_rsp_last;
        end else begin
          to_m0_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_m0_rd_rsp_data  = from_mem_rd_rsp_data;
          to_m0_rd_rsp_last  = from_mem_rd_rsp_last;
        end
        // Any beat past a full line is an overrun; the counter saturates.
        if (beat_xfer) begin
          if (beat_cnt_q >= CntMax) begin
            overrun_d = 1'b1;
          end
          if (beat_cnt_q != CntSat) begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          end
          if (from_mem_rd_rsp_last) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

  assign to_mem_rd_req_addr = addr_q;
  assign grant_id           = grant_q;
  assign busy               = (state_q != IDLE);
  assign overrun_err        = overrun_q;

endmodule
